// File: rtl/writeback_stage_if.sv
// MEM-to-WB bundle: instruction fields and data-memory response in, register-file
// write port, HI/LO and stall/error status out.
interface writeback_stage_if;
    logic        valid_mem;
    logic [31:0] res_mem;
    logic [31:0] res_hi_mem;
    logic [31:0] res_lo_mem;
    logic [1:0]  mem_to_reg_mem;
    logic        wr_reg_en_mem;
    logic [4:0]  wr_reg_addr_mem;
    logic        link_mem;
    logic [31:0] PC4_mem;
    logic        hi_wr_en_mem;
    logic        lo_wr_en_mem;
    logic [1:0]  load_size_mem;
    logic        sign_zero_ext_mem;
    logic [31:0] rd_data;
    logic        rd_valid;

    logic        wb_stall;
    logic        bus_err;
    logic [31:0] res_wb;
    logic [4:0]  wr_reg_addr_wb;
    logic        wr_reg_en_wb;
    logic [31:0] hi_wb;
    logic [31:0] lo_wb;
    logic        hi_wr_en_wb;
    logic        lo_wr_en_wb;

    modport master (
        output valid_mem, res_mem, res_hi_mem, res_lo_mem, mem_to_reg_mem,
               wr_reg_en_mem, wr_reg_addr_mem, link_mem, PC4_mem,
               hi_wr_en_mem, lo_wr_en_mem, load_size_mem, sign_zero_ext_mem,
               rd_data, rd_valid,
        input  wb_stall, bus_err, res_wb, wr_reg_addr_wb, wr_reg_en_wb,
               hi_wb, lo_wb, hi_wr_en_wb, lo_wr_en_wb
    );

    modport slave (
        input  valid_mem, res_mem, res_hi_mem, res_lo_mem, mem_to_reg_mem,
               wr_reg_en_mem, wr_reg_addr_mem, link_mem, PC4_mem,
               hi_wr_en_mem, lo_wr_en_mem, load_size_mem, sign_zero_ext_mem,
               rd_data, rd_valid,
        output wb_stall, bus_err, res_wb, wr_reg_addr_wb, wr_reg_en_wb,
               hi_wb, lo_wb, hi_wr_en_wb, lo_wr_en_wb
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register: selects ALU / load / link result for the GPR write port,
// waits on late data-memory responses with a timeout, and owns architectural HI/LO.
module writeback_stage #(
    parameter int unsigned LOAD_TIMEOUT = 16,
    parameter logic [4:0]  LINK_REG     = 5'd31
) (
    input logic               clk,
    input logic               reset,
    writeback_stage_if.slave  wb
);

    typedef enum logic [0:0] {
        IDLE,
        WAIT_LOAD
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(LOAD_TIMEOUT);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [4:0]  addr_q;
    logic        wen_q;

    logic [31:0] res_q;
    logic [4:0]  waddr_q;
    logic        wen_wb_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        hi_en_q;
    logic        lo_en_q;
    logic        bus_err_q;

    logic        is_load_d;
    logic        is_link_d;
    logic [4:0]  dest_d;
    logic        wen_d;
    logic [31:0] nonload_res_d;
    logic [31:0] load_now_d;
    logic [31:0] load_wait_d;

    // Big-endian lane pick: offset 0 addresses the most significant byte.
    function automatic logic [31:0] extract(input logic [31:0] data,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic        sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = data[31:24];
            2'd1:    b = data[23:16];
            2'd2:    b = data[15:8];
            default: b = data[7:0];
        endcase
        h = off[1] ? data[15:0] : data[31:16];
        case (size)
            2'b01:   r = {{16{sext & h[15]}}, h};
            2'b10:   r = {{24{sext & b[7]}}, b};
            default: r = data;
        endcase
        return r;
    endfunction

    always_comb begin
        is_link_d     = wb.link_mem || (wb.mem_to_reg_mem == 2'b10);
        is_load_d     = (wb.mem_to_reg_mem == 2'b01) && !wb.link_mem;
        dest_d        = wb.link_mem ? LINK_REG : wb.wr_reg_addr_mem;
        wen_d         = wb.wr_reg_en_mem && (dest_d != 5'd0);
        nonload_res_d = is_link_d ? (wb.PC4_mem + 32'd4) : wb.res_mem;
        load_now_d    = extract(wb.rd_data, wb.res_mem[1:0], wb.load_size_mem,
                                wb.sign_zero_ext_mem);
        load_wait_d   = extract(wb.rd_data, off_q, size_q, sext_q);
    end

    // Load fields are latched on entry to WAIT_LOAD so the MEM bus is not relied on while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            off_q     <= 2'd0;
            size_q    <= 2'd0;
            sext_q    <= 1'b0;
            addr_q    <= 5'd0;
            wen_q     <= 1'b0;
            res_q     <= 32'd0;
            waddr_q   <= 5'd0;
            wen_wb_q  <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hi_en_q   <= 1'b0;
            lo_en_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            wen_wb_q  <= 1'b0;
            hi_en_q   <= 1'b0;
            lo_en_q   <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wb.valid_mem) begin
                        if (wb.hi_wr_en_mem) begin
                            hi_q    <= wb.res_hi_mem;
                            hi_en_q <= 1'b1;
                        end
                        if (wb.lo_wr_en_mem) begin
                            lo_q    <= wb.res_lo_mem;
                            lo_en_q <= 1'b1;
                        end
                        if (is_load_d && !wb.rd_valid) begin
                            state_q <= WAIT_LOAD;
                            cnt_q   <= 8'd1;
                            off_q   <= wb.res_mem[1:0];
                            size_q  <= wb.load_size_mem;
                            sext_q  <= wb.sign_zero_ext_mem;
                            addr_q  <= dest_d;
                            wen_q   <= wen_d;
                        end else begin
                            res_q    <= is_load_d ? load_now_d : nonload_res_d;
                            waddr_q  <= dest_d;
                            wen_wb_q <= wen_d;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (wb.rd_valid) begin
                        res_q    <= load_wait_d;
                        waddr_q  <= addr_q;
                        wen_wb_q <= wen_q;
                        state_q  <= IDLE;
                        cnt_q    <= 8'd0;
                    end else if (cnt_q >= TIMEOUT_C) begin
                        bus_err_q <= 1'b1;
                        state_q   <= IDLE;
                        cnt_q     <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    assign wb.wb_stall       = (state_q == WAIT_LOAD);
    assign wb.bus_err        = bus_err_q;
    assign wb.res_wb         = res_q;
    assign wb.wr_reg_addr_wb = waddr_q;
    assign wb.wr_reg_en_wb   = wen_wb_q;
    assign wb.hi_wb          = hi_q;
    assign wb.lo_wb          = lo_q;
    assign wb.hi_wr_en_wb    = hi_en_q;
    assign wb.lo_wr_en_wb    = lo_en_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: result selection, load extraction, wait states,
// timeout, register 0, link, HI/LO and reset during a pending load.
module tb_writeback_stage;

    logic clk;
    logic reset;
    int   checkCount;
    int   errorCount;
    int   stallCount;
    int   busErrCount;
    int   writeCount;

    writeback_stage_if wbIf ();

    writeback_stage #(
        .LOAD_TIMEOUT(16),
        .LINK_REG    (5'd31)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .wb   (wbIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] res,
                                 input logic [1:0] m2r, input logic wen,
                                 input logic [4:0] addr, input logic link,
                                 input logic [31:0] pc4, input logic [1:0] size,
                                 input logic sext, input logic [31:0] rdData,
                                 input logic rdValid);
        wbIf.valid_mem         = valid;
        wbIf.res_mem           = res;
        wbIf.mem_to_reg_mem    = m2r;
        wbIf.wr_reg_en_mem     = wen;
        wbIf.wr_reg_addr_mem   = addr;
        wbIf.link_mem          = link;
        wbIf.PC4_mem           = pc4;
        wbIf.load_size_mem     = size;
        wbIf.sign_zero_ext_mem = sext;
        wbIf.rd_data           = rdData;
        wbIf.rd_valid          = rdValid;
        wbIf.hi_wr_en_mem      = 1'b0;
        wbIf.lo_wr_en_mem      = 1'b0;
        wbIf.res_hi_mem        = 32'd0;
        wbIf.res_lo_mem        = 32'd0;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        reset       = 1'b0;
        applyIdle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_res",   wbIf.res_wb, 32'd0);
        checkOutput("rst_wen",   32'(wbIf.wr_reg_en_wb), 32'd0);
        checkOutput("rst_stall", 32'(wbIf.wb_stall), 32'd0);
        checkOutput("rst_hi",    wbIf.hi_wb, 32'd0);
        checkOutput("rst_lo",    wbIf.lo_wb, 32'd0);
        checkOutput("rst_berr",  32'(wbIf.bus_err), 32'd0);
        reset = 1'b1;

        // ALU result to r5, strobe for exactly one cycle
        applyStimulus(1'b1, 32'h0000_1234, 2'b00, 1'b1, 5'd5, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0, 1'b0);
        step();
        checkOutput("alu_res",  wbIf.res_wb, 32'h0000_1234);
        checkOutput("alu_addr", 32'(wbIf.wr_reg_addr_wb), 32'd5);
        checkOutput("alu_wen",  32'(wbIf.wr_reg_en_wb), 32'd1);
        applyIdle();
        step();
        checkOutput("alu_wen_pulse", 32'(wbIf.wr_reg_en_wb), 32'd0);

        // Same-cycle loads: byte signed/unsigned, half, word, byte offset 0
        applyStimulus(1'b1, 32'h1000_0002, 2'b01, 1'b1, 5'd8, 1'b0, 32'd0, 2'b10, 1'b1, 32'h1122_8344, 1'b1);
        step();
        checkOutput("lb_res",  wbIf.res_wb, 32'hFFFF_FF83);
        checkOutput("lb_addr", 32'(wbIf.wr_reg_addr_wb), 32'd8);
        checkOutput("lb_wen",  32'(wbIf.wr_reg_en_wb), 32'd1);
        applyStimulus(1'b1, 32'h1000_0002, 2'b01, 1'b1, 5'd8, 1'b0, 32'd0, 2'b10, 1'b0, 32'h1122_8344, 1'b1);
        step();
        checkOutput("lbu_res", wbIf.res_wb, 32'h0000_0083);
        applyStimulus(1'b1, 32'h1000_0003, 2'b01, 1'b1, 5'd9, 1'b0, 32'd0, 2'b01, 1'b1, 32'h1122_8344, 1'b1);
        step();
        checkOutput("lh_res",  wbIf.res_wb, 32'hFFFF_8344);
        applyStimulus(1'b1, 32'h1000_0000, 2'b01, 1'b1, 5'd9, 1'b0, 32'd0, 2'b01, 1'b0, 32'h8765_4321, 1'b1);
        step();
        checkOutput("lhu_hi_res", wbIf.res_wb, 32'h0000_8765);
        applyStimulus(1'b1, 32'h1000_0001, 2'b01, 1'b1, 5'd10, 1'b0, 32'd0, 2'b00, 1'b1, 32'h1122_8344, 1'b1);
        step();
        checkOutput("lw_res",  wbIf.res_wb, 32'h1122_8344);
        applyStimulus(1'b1, 32'h1000_0000, 2'b01, 1'b1, 5'd10, 1'b0, 32'd0, 2'b10, 1'b1, 32'h7F00_00FF, 1'b1);
        step();
        checkOutput("lb0_res", wbIf.res_wb, 32'h0000_007F);

        // Link forces r31 and PC+8
        applyStimulus(1'b1, 32'h0000_0BAD, 2'b10, 1'b1, 5'd7, 1'b1, 32'h0040_0010, 2'b00, 1'b0, 32'd0, 1'b0);
        step();
        checkOutput("link_res",  wbIf.res_wb, 32'h0040_0014);
        checkOutput("link_addr", 32'(wbIf.wr_reg_addr_wb), 32'd31);
        checkOutput("link_wen",  32'(wbIf.wr_reg_en_wb), 32'd1);

        // Destination r0 never writes
        applyStimulus(1'b1, 32'h0000_5555, 2'b00, 1'b1, 5'd0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0, 1'b0);
        step();
        checkOutput("r0_wen", 32'(wbIf.wr_reg_en_wb), 32'd0);

        // Load answered three cycles late: unsigned byte at offset 1
        stallCount = 0;
        applyStimulus(1'b1, 32'h2000_0001, 2'b01, 1'b1, 5'd12, 1'b0, 32'd0, 2'b10, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (wbIf.wb_stall) stallCount++;
            checkOutput("wait_no_wen", 32'(wbIf.wr_reg_en_wb), 32'd0);
        end
        checkOutput("wait_stall_cycles", 32'(stallCount), 32'd3);
        wbIf.rd_data  = 32'hCAFE_BABE;
        wbIf.rd_valid = 1'b1;
        step();
        checkOutput("wait_stall_off", 32'(wbIf.wb_stall), 32'd0);
        checkOutput("wait_wen",  32'(wbIf.wr_reg_en_wb), 32'd1);
        checkOutput("wait_res",  wbIf.res_wb, 32'h0000_00FE);
        checkOutput("wait_addr", 32'(wbIf.wr_reg_addr_wb), 32'd12);
        applyIdle();
        step();
        checkOutput("wait_wen_pulse", 32'(wbIf.wr_reg_en_wb), 32'd0);

        // No response: 16 stalled cycles, one bus_err, no write
        stallCount  = 0;
        busErrCount = 0;
        writeCount  = 0;
        applyStimulus(1'b1, 32'h3000_0000, 2'b01, 1'b1, 5'd13, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (wbIf.wb_stall) stallCount++;
            if (wbIf.bus_err) busErrCount++;
            if (wbIf.wr_reg_en_wb) writeCount++;
            if (!wbIf.wb_stall) applyIdle();
        end
        checkOutput("to_stall_cycles", 32'(stallCount), 32'd16);
        checkOutput("to_bus_err",      32'(busErrCount), 32'd1);
        checkOutput("to_no_write",     32'(writeCount), 32'd0);
        checkOutput("to_released",     32'(wbIf.wb_stall), 32'd0);

        // HI/LO updates, then HI alone
        applyStimulus(1'b1, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0, 1'b0);
        wbIf.hi_wr_en_mem = 1'b1;
        wbIf.lo_wr_en_mem = 1'b1;
        wbIf.res_hi_mem   = 32'hDEAD_BEEF;
        wbIf.res_lo_mem   = 32'h0000_0001;
        step();
        checkOutput("hilo_hi",    wbIf.hi_wb, 32'hDEAD_BEEF);
        checkOutput("hilo_lo",    wbIf.lo_wb, 32'h0000_0001);
        checkOutput("hilo_hi_en", 32'(wbIf.hi_wr_en_wb), 32'd1);
        checkOutput("hilo_lo_en", 32'(wbIf.lo_wr_en_wb), 32'd1);
        applyStimulus(1'b1, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0, 1'b0);
        wbIf.hi_wr_en_mem = 1'b1;
        wbIf.res_hi_mem   = 32'h1234_5678;
        wbIf.res_lo_mem   = 32'hFFFF_FFFF;
        step();
        checkOutput("hi_only_hi",    wbIf.hi_wb, 32'h1234_5678);
        checkOutput("hi_only_lo",    wbIf.lo_wb, 32'h0000_0001);
        checkOutput("hi_only_lo_en", 32'(wbIf.lo_wr_en_wb), 32'd0);
        applyIdle();
        step();
        checkOutput("hilo_en_pulse", 32'(wbIf.hi_wr_en_wb), 32'd0);

        // Reset while a load is pending aborts it
        applyStimulus(1'b1, 32'h4000_0000, 2'b01, 1'b1, 5'd14, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0, 1'b0);
        step();
        checkOutput("rw_stall_before", 32'(wbIf.wb_stall), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rw_stall",  32'(wbIf.wb_stall), 32'd0);
        checkOutput("rw_res",    wbIf.res_wb, 32'd0);
        checkOutput("rw_hi",     wbIf.hi_wb, 32'd0);
        checkOutput("rw_lo",     wbIf.lo_wb, 32'd0);
        checkOutput("rw_addr",   32'(wbIf.wr_reg_addr_wb), 32'd0);
        #1;
        reset = 1'b1;
        applyIdle();
        wbIf.rd_data  = 32'h5A5A_5A5A;
        wbIf.rd_valid = 1'b1;
        step();
        checkOutput("rw_idle_rdvalid_wen", 32'(wbIf.wr_reg_en_wb), 32'd0);
        checkOutput("rw_idle_stall",       32'(wbIf.wb_stall), 32'd0);
        applyIdle();
        step();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
